// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and control bundle for the pipelined RV32I control unit
package pipe_ctrl_pkg;

  localparam int RAW = 5;
  localparam int AW  = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_R = 3'b111;

  localparam logic [AW-1:0] ALU_ADD  = 4'd0;
  localparam logic [AW-1:0] ALU_SUB  = 4'd1;
  localparam logic [AW-1:0] ALU_SLL  = 4'd2;
  localparam logic [AW-1:0] ALU_SLT  = 4'd3;
  localparam logic [AW-1:0] ALU_SLTU = 4'd4;
  localparam logic [AW-1:0] ALU_XOR  = 4'd5;
  localparam logic [AW-1:0] ALU_SRL  = 4'd6;
  localparam logic [AW-1:0] ALU_SRA  = 4'd7;
  localparam logic [AW-1:0] ALU_OR   = 4'd8;
  localparam logic [AW-1:0] ALU_AND  = 4'd9;
  localparam logic [AW-1:0] ALU_NOP  = 4'hF;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic          asel;
    logic          bsel;
    logic [AW-1:0] alusel;
    logic          brun;
    logic          memrw;
    logic          regwen;
    logic [1:0]    wbsel;
    logic [RAW-1:0] rd;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
    logic          is_load;
    logic          is_branch;
    logic          is_jump;
    logic [2:0]    funct3;
    logic          valid;
  } ctrl_bundle_t;

  // Bubble: invalid, no enables, ALU idle, rs fields x0 so it never matches a hazard
  localparam ctrl_bundle_t BUBBLE = '{
    asel: 1'b0, bsel: 1'b0, alusel: ALU_NOP, brun: 1'b0, memrw: 1'b0,
    regwen: 1'b0, wbsel: WB_ALU, rd: '0, rs1: '0, rs2: '0,
    is_load: 1'b0, is_branch: 1'b0, is_jump: 1'b0, funct3: 3'b000, valid: 1'b0
  };

  // funct3 plus the funct7[5] alternate bit select the ALU operation
  function automatic logic [AW-1:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_op = ALU_SLL;
      3'd2:    alu_op = ALU_SLT;
      3'd3:    alu_op = ALU_SLTU;
      3'd4:    alu_op = ALU_XOR;
      3'd5:    alu_op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational ID-stage decode of one RV32I instruction into a control bundle
module ctrl_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic         valid,
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic [2:0]   imm_sel,
  output logic         illegal
);

  logic [6:0]     op;
  logic [2:0]     f3;
  logic [6:0]     f7;
  logic [RAW-1:0] rd;
  logic [RAW-1:0] rs1;
  logic [RAW-1:0] rs2;
  logic           legal;
  ctrl_bundle_t   b;

  assign op  = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  // Register indices are only recorded when the instruction really reads/writes them
  always_comb begin
    b         = BUBBLE;
    legal     = 1'b0;
    imm_sel   = IMM_I;
    b.funct3  = f3;
    b.brun    = f3[1];
    case (op)
      OP_R: begin
        imm_sel  = IMM_R;
        legal    = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        b.alusel = alu_op(f3, f7[5]);
        b.rs1    = rs1;
        b.rs2    = rs2;
        b.regwen = 1'b1;
        b.rd     = rd;
      end
      OP_IMM: begin
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                 legal = 1'b1;
        b.alusel = alu_op(f3, (f3 == 3'd5) && f7[5]);
        b.bsel   = 1'b1;
        b.rs1    = rs1;
        b.regwen = 1'b1;
        b.rd     = rd;
      end
      OP_LOAD: begin
        legal     = (f3 == 3'd2);
        b.alusel  = ALU_ADD;
        b.bsel    = 1'b1;
        b.rs1     = rs1;
        b.regwen  = 1'b1;
        b.rd      = rd;
        b.wbsel   = WB_MEM;
        b.is_load = 1'b1;
      end
      OP_STORE: begin
        imm_sel  = IMM_S;
        legal    = (f3 == 3'd2);
        b.alusel = ALU_ADD;
        b.bsel   = 1'b1;
        b.rs1    = rs1;
        b.rs2    = rs2;
        b.memrw  = 1'b1;
      end
      OP_BRANCH: begin
        imm_sel     = IMM_B;
        legal       = (f3 != 3'd2) && (f3 != 3'd3);
        b.alusel    = ALU_ADD;
        b.asel      = 1'b1;
        b.bsel      = 1'b1;
        b.rs1       = rs1;
        b.rs2       = rs2;
        b.is_branch = 1'b1;
      end
      OP_JAL: begin
        imm_sel   = IMM_J;
        legal     = 1'b1;
        b.alusel  = ALU_ADD;
        b.asel    = 1'b1;
        b.bsel    = 1'b1;
        b.regwen  = 1'b1;
        b.rd      = rd;
        b.wbsel   = WB_PC4;
        b.is_jump = 1'b1;
      end
      OP_JALR: begin
        legal     = (f3 == 3'd0);
        b.alusel  = ALU_ADD;
        b.bsel    = 1'b1;
        b.rs1     = rs1;
        b.regwen  = 1'b1;
        b.rd      = rd;
        b.wbsel   = WB_PC4;
        b.is_jump = 1'b1;
      end
      OP_AUIPC: begin
        imm_sel  = IMM_U;
        legal    = 1'b1;
        b.alusel = ALU_ADD;
        b.asel   = 1'b1;
        b.bsel   = 1'b1;
        b.regwen = 1'b1;
        b.rd     = rd;
      end
      OP_LUI: begin
        // x0 + imm: rs1 stays x0 so lui never forwards or stalls
        imm_sel  = IMM_U;
        legal    = 1'b1;
        b.alusel = ALU_ADD;
        b.bsel   = 1'b1;
        b.regwen = 1'b1;
        b.rd     = rd;
      end
      default: legal = 1'b0;
    endcase
    if (valid && legal) b.valid = 1'b1;
    else                b = BUBBLE;
    ctrl    = b;
    illegal = valid && !legal;
  end

endmodule

// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - 5-stage RV32I control: decode, stage registers, branch, hazard and forwarding
module pipe_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int ALUSEL_W  = 4,
  parameter bit HAZARD_EN = 1'b1,
  parameter bit FWD_EN    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  input  logic                ex_BrEq,
  input  logic                ex_BrLT,
  output logic [2:0]          ImmSel,
  output logic                ex_ASel,
  output logic                ex_BSel,
  output logic [ALUSEL_W-1:0] ex_ALUSel,
  output logic                ex_BrUn,
  output logic [1:0]          PCSel,
  output logic                stall_if,
  output logic                stall_id,
  output logic                flush_id,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                mem_MemRW,
  output logic                wb_RegWEn,
  output logic [1:0]          wb_WBSel,
  output logic [REG_AW-1:0]   wb_rd,
  output logic                illegal
);

  ctrl_bundle_t id_ctrl;
  ctrl_bundle_t ex_q;
  ctrl_bundle_t mem_q;
  ctrl_bundle_t wb_q;
  logic         dec_illegal;
  logic         taken;
  logic         redirect;
  logic         load_use;
  logic         mem_wr;
  logic         wb_wr;
  logic         unused_wb_bits;

  ctrl_decoder u_dec (
    .valid   (id_valid),
    .instr   (id_instr),
    .ctrl    (id_ctrl),
    .imm_sel (ImmSel),
    .illegal (dec_illegal)
  );

  // Branch condition and redirect decision for the instruction in EX
  always_comb begin
    taken = 1'b0;
    case (ex_q.funct3)
      3'd0:       taken = ex_BrEq;
      3'd1:       taken = !ex_BrEq;
      3'd4, 3'd6: taken = ex_BrLT;
      3'd5, 3'd7: taken = !ex_BrLT;
      default:    taken = 1'b0;
    endcase
    redirect = ex_q.valid && ((ex_q.is_branch && taken) || ex_q.is_jump);
    PCSel    = PC_PLUS4;
    if (redirect && !rst) PCSel = ex_q.is_jump ? PC_JUMP : PC_BRANCH;
  end

  // Load-use interlock; a redirect squashes the dependent instruction, so it never stalls
  always_comb begin
    load_use = HAZARD_EN && ex_q.valid && ex_q.is_load && (ex_q.rd != '0) &&
               ((ex_q.rd == id_ctrl.rs1) || (ex_q.rd == id_ctrl.rs2));
    stall_if = load_use && !redirect && !rst;
    stall_id = stall_if;
    flush_id = redirect && !rst;
    illegal  = dec_illegal && !redirect && !rst;
  end

  // Operand bypass selects; the younger EX/MEM result wins over WB
  always_comb begin
    mem_wr = mem_q.valid && mem_q.regwen && (mem_q.rd != '0);
    wb_wr  = wb_q.valid && wb_q.regwen && (wb_q.rd != '0);
    fwd_a  = FWD_RF;
    fwd_b  = FWD_RF;
    if (FWD_EN && !rst) begin
      if (mem_wr && mem_q.rd == ex_q.rs1)     fwd_a = FWD_MEM;
      else if (wb_wr && wb_q.rd == ex_q.rs1)  fwd_a = FWD_WB;
      if (mem_wr && mem_q.rd == ex_q.rs2)     fwd_b = FWD_MEM;
      else if (wb_wr && wb_q.rd == ex_q.rs2)  fwd_b = FWD_WB;
    end
  end

  // Stage registers: reset or redirect/interlock inject bubbles, otherwise advance one stage
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      ex_q  <= (redirect || load_use) ? BUBBLE : id_ctrl;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_ASel   = ex_q.asel;
  assign ex_BSel   = ex_q.bsel;
  assign ex_ALUSel = (ex_q.alusel == ALU_NOP) ? '1 : ALUSEL_W'(ex_q.alusel);
  assign ex_BrUn   = ex_q.brun;
  assign mem_MemRW = mem_q.memrw;
  assign wb_RegWEn = wb_q.regwen;
  assign wb_WBSel  = wb_q.wbsel;
  assign wb_rd     = REG_AW'(wb_q.rd);

  assign unused_wb_bits = ^wb_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - directed table and sequence checks for pipe_control_unit
module tb_pipe_control_unit;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_BrEq;
  logic        ex_BrLT;
  logic [2:0]  ImmSel;
  logic        ex_ASel;
  logic        ex_BSel;
  logic [3:0]  ex_ALUSel;
  logic        ex_BrUn;
  logic [1:0]  PCSel;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_MemRW;
  logic        wb_RegWEn;
  logic [1:0]  wb_WBSel;
  logic [4:0]  wb_rd;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_control_unit #(.REG_AW(5), .ALUSEL_W(4), .HAZARD_EN(1'b1), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .ex_BrEq(ex_BrEq), .ex_BrLT(ex_BrLT), .ImmSel(ImmSel), .ex_ASel(ex_ASel),
    .ex_BSel(ex_BSel), .ex_ALUSel(ex_ALUSel), .ex_BrUn(ex_BrUn), .PCSel(PCSel),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_MemRW(mem_MemRW), .wb_RegWEn(wb_RegWEn),
    .wb_WBSel(wb_WBSel), .wb_rd(wb_rd), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        br_eq;
    logic        br_lt;
    logic [2:0]  imm;
    logic        ill;
    logic        asel;
    logic        bsel;
    logic [3:0]  alu;
    logic        brun;
    logic [1:0]  pcsel;
    logic        flush;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] b_t(input logic [2:0] f3, input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, f3, 5'd0, 7'h63};
  endfunction

  function automatic logic [31:0] s_t(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'd2, 5'd0, 7'h23};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic eq, input logic lt,
                              input logic [2:0] imm, input logic ill, input logic asel, input logic bsel,
                              input logic [3:0] alu, input logic brun, input logic [1:0] pcsel, input logic flush);
    vec_t v;
    v.instr = instr; v.br_eq = eq; v.br_lt = lt; v.imm = imm; v.ill = ill;
    v.asel = asel; v.bsel = bsel; v.alu = alu; v.brun = brun; v.pcsel = pcsel; v.flush = flush;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr);
    id_valid = v;
    id_instr = instr;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = 32'd0; ex_BrEq = 1'b0; ex_BrLT = 1'b0;

    //                instr                                   eq lt imm    ill as bs alu   bu pc     fl
    vecs[0]  = mk(r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3),         0, 0, 3'b111, 0, 0, 0, 4'd0, 0, 2'b00, 0);
    vecs[1]  = mk(r_t(7'h20, 5'd1, 5'd3, 3'd0, 5'd4),         0, 0, 3'b111, 0, 0, 0, 4'd1, 0, 2'b00, 0);
    vecs[2]  = mk(r_t(7'h20, 5'd2, 5'd1, 3'd5, 5'd5),         0, 0, 3'b111, 0, 0, 0, 4'd7, 0, 2'b00, 0);
    vecs[3]  = mk(r_t(7'h00, 5'd2, 5'd1, 3'd7, 5'd5),         0, 0, 3'b111, 0, 0, 0, 4'd9, 1, 2'b00, 0);
    vecs[4]  = mk(r_t(7'h00, 5'd2, 5'd1, 3'd3, 5'd5),         0, 0, 3'b111, 0, 0, 0, 4'd4, 1, 2'b00, 0);
    vecs[5]  = mk(i_t(12'd7, 5'd1, 3'd2, 5'd5, 7'h13),        0, 0, 3'b000, 0, 0, 1, 4'd3, 1, 2'b00, 0);
    vecs[6]  = mk(i_t({7'h20, 5'd3}, 5'd1, 3'd5, 5'd5, 7'h13),0, 0, 3'b000, 0, 0, 1, 4'd7, 0, 2'b00, 0);
    vecs[7]  = mk(i_t(12'd4, 5'd1, 3'd2, 5'd5, 7'h03),        0, 0, 3'b000, 0, 0, 1, 4'd0, 1, 2'b00, 0);
    vecs[8]  = mk(s_t(5'd2, 5'd1),                            0, 0, 3'b001, 0, 0, 1, 4'd0, 1, 2'b00, 0);
    vecs[9]  = mk(b_t(3'd6, 5'd2, 5'd1),                      0, 1, 3'b010, 0, 1, 1, 4'd0, 1, 2'b01, 1);
    vecs[10] = mk(b_t(3'd7, 5'd2, 5'd1),                      0, 0, 3'b010, 0, 1, 1, 4'd0, 1, 2'b01, 1);
    vecs[11] = mk(b_t(3'd0, 5'd2, 5'd1),                      0, 0, 3'b010, 0, 1, 1, 4'd0, 0, 2'b00, 0);
    vecs[12] = mk(b_t(3'd5, 5'd2, 5'd1),                      0, 1, 3'b010, 0, 1, 1, 4'd0, 0, 2'b00, 0);
    vecs[13] = mk({20'd0, 5'd1, 7'h6F},                       0, 0, 3'b011, 0, 1, 1, 4'd0, 0, 2'b10, 1);
    vecs[14] = mk({20'h12345, 5'd5, 7'h17},                   0, 0, 3'b100, 0, 1, 1, 4'd0, 0, 2'b00, 0);
    vecs[15] = mk({20'h12345, 5'd5, 7'h37},                   0, 0, 3'b100, 0, 0, 1, 4'd0, 0, 2'b00, 0);
    vecs[16] = mk({25'd0, 7'h7F},                             0, 0, 3'b000, 1, 0, 0, 4'hF, 0, 2'b00, 0);
    vecs[17] = mk(r_t(7'h01, 5'd2, 5'd1, 3'd0, 5'd3),         0, 0, 3'b111, 1, 0, 0, 4'hF, 0, 2'b00, 0);
    vecs[18] = mk(i_t({7'h20, 5'd1}, 5'd1, 3'd1, 5'd5, 7'h13),0, 0, 3'b000, 1, 0, 0, 4'hF, 0, 2'b00, 0);
    vecs[19] = mk(b_t(3'd2, 5'd2, 5'd1),                      0, 0, 3'b010, 1, 0, 0, 4'hF, 0, 2'b00, 0);

    // Reset state
    tick(); tick();
    chk("rst_alusel", ex_ALUSel, 4'hF);
    chk("rst_asel", ex_ASel, 0);
    chk("rst_bsel", ex_BSel, 0);
    chk("rst_brun", ex_BrUn, 0);
    chk("rst_pcsel", PCSel, 0);
    chk("rst_stall", stall_if, 0);
    chk("rst_flush", flush_id, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_memrw", mem_MemRW, 0);
    chk("rst_regwen", wb_RegWEn, 0);
    chk("rst_wbsel", wb_WBSel, 2'b01);
    chk("rst_wbrd", wb_rd, 0);
    rst = 1'b0;
    tick();

    // Per-instruction decode and EX resolution; one idle cycle between vectors
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, vecs[i].instr);
      ex_BrEq = vecs[i].br_eq;
      ex_BrLT = vecs[i].br_lt;
      #1;
      chk($sformatf("v%0d_immsel", i), ImmSel, vecs[i].imm);
      chk($sformatf("v%0d_illegal", i), illegal, vecs[i].ill);
      tick();
      chk($sformatf("v%0d_asel", i), ex_ASel, vecs[i].asel);
      chk($sformatf("v%0d_bsel", i), ex_BSel, vecs[i].bsel);
      chk($sformatf("v%0d_alusel", i), ex_ALUSel, vecs[i].alu);
      chk($sformatf("v%0d_brun", i), ex_BrUn, vecs[i].brun);
      chk($sformatf("v%0d_pcsel", i), PCSel, vecs[i].pcsel);
      chk($sformatf("v%0d_flush", i), flush_id, vecs[i].flush);
      drive(1'b0, 32'd0);
      tick();
      chk($sformatf("v%0d_ill_gone", i), illegal, 0);
    end
    ex_BrEq = 1'b0; ex_BrLT = 1'b0;
    tick(); tick(); tick();

    // add x3 ; add x3 ; sub x4,x3,x3 : EX/MEM beats WB, and first add reaches WB
    drive(1'b1, r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3)); tick();
    drive(1'b1, r_t(7'h00, 5'd2, 5'd2, 3'd0, 5'd3)); tick();
    drive(1'b1, r_t(7'h20, 5'd3, 5'd3, 3'd0, 5'd4)); tick();
    chk("fwd_pri_a", fwd_a, 2'b01);
    chk("fwd_pri_b", fwd_b, 2'b01);
    chk("fwd_wb_regwen", wb_RegWEn, 1);
    chk("fwd_wb_rd", wb_rd, 5'd3);
    drive(1'b0, 32'd0); tick(); tick(); tick();

    // add x3,x1,x2 then sub x4,x3,x1
    drive(1'b1, r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3)); tick();
    drive(1'b1, r_t(7'h20, 5'd1, 5'd3, 3'd0, 5'd4)); tick();
    chk("t1_fwd_a", fwd_a, 2'b01);
    chk("t1_fwd_b", fwd_b, 2'b00);
    drive(1'b0, 32'd0); tick();
    chk("t1_wb_regwen", wb_RegWEn, 1);
    chk("t1_wb_rd", wb_rd, 5'd3);
    tick(); tick(); tick();

    // lw x5,0(x1) then add x6,x5,x2: one stall, bubble, then WB forward
    drive(1'b1, i_t(12'd0, 5'd1, 3'd2, 5'd5, 7'h03)); tick();
    drive(1'b1, r_t(7'h00, 5'd2, 5'd5, 3'd0, 5'd6)); #1;
    chk("t2_stall_if", stall_if, 1);
    chk("t2_stall_id", stall_id, 1);
    chk("t2_flush", flush_id, 0);
    tick();
    chk("t2_bubble", ex_ALUSel, 4'hF);
    chk("t2_stall_once", stall_if, 0);
    tick();
    chk("t2_add_in_ex", ex_ALUSel, 4'd0);
    chk("t2_fwd_a", fwd_a, 2'b10);
    drive(1'b0, 32'd0); tick(); tick(); tick();

    // lw x0 then a reader of x0: rd = x0 never stalls
    drive(1'b1, i_t(12'd0, 5'd1, 3'd2, 5'd0, 7'h03)); tick();
    drive(1'b1, r_t(7'h00, 5'd2, 5'd0, 3'd0, 5'd6)); #1;
    chk("x0_no_stall", stall_if, 0);
    drive(1'b0, 32'd0); tick(); tick(); tick(); tick();

    // bne taken squashes the following instruction; not taken lets it through
    drive(1'b1, b_t(3'd1, 5'd2, 5'd1)); ex_BrEq = 1'b0; tick();
    drive(1'b1, r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3)); #1;
    chk("t3_pcsel_taken", PCSel, 2'b01);
    chk("t3_flush_taken", flush_id, 1);
    tick();
    chk("t3_bubble", ex_ALUSel, 4'hF);
    drive(1'b1, b_t(3'd1, 5'd2, 5'd1)); ex_BrEq = 1'b1; tick();
    drive(1'b1, r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3)); #1;
    chk("t3_pcsel_nt", PCSel, 2'b00);
    chk("t3_flush_nt", flush_id, 0);
    tick();
    chk("t3_passes", ex_ALUSel, 4'd0);
    drive(1'b0, 32'd0); ex_BrEq = 1'b0; tick(); tick(); tick(); tick();

    // jalr x1,0(x2) with a dependent instruction behind it
    drive(1'b1, i_t(12'd0, 5'd2, 3'd0, 5'd1, 7'h67)); tick();
    drive(1'b1, r_t(7'h00, 5'd1, 5'd1, 3'd0, 5'd6)); #1;
    chk("t4_pcsel", PCSel, 2'b10);
    chk("t4_flush", flush_id, 1);
    chk("t4_no_stall", stall_if, 0);
    drive(1'b0, 32'd0); tick(); tick();
    chk("t4_wbsel", wb_WBSel, 2'b10);
    chk("t4_regwen", wb_RegWEn, 1);
    chk("t4_rd", wb_rd, 5'd1);
    tick(); tick();

    // add x7 then sw x7: store data operand is forwarded and the store reaches MEM
    drive(1'b1, r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd7)); tick();
    drive(1'b1, s_t(5'd7, 5'd3)); tick();
    chk("sw_fwd_b", fwd_b, 2'b01);
    chk("sw_fwd_a", fwd_a, 2'b00);
    drive(1'b0, 32'd0); tick();
    chk("sw_memrw", mem_MemRW, 1);
    tick(); tick(); tick();

    // Reset while a store sits in EX: it never reaches MEM
    drive(1'b1, s_t(5'd7, 5'd3)); tick();
    drive(1'b0, 32'd0); rst = 1'b1; tick();
    chk("rst_mid_sw", mem_MemRW, 0);
    rst = 1'b0; tick();
    chk("rst_mid_sw_after", mem_MemRW, 0);
    chk("rst_mid_regwen", wb_RegWEn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
